// File: rtl/mem_access_if.sv
// Data bus between the MEM stage and the data memory: single outstanding
// request held until a one-cycle ack strobe.
interface mem_access_if #(
   parameter int ADDR_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [3:0]        sel;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              ack;

   modport master (
      output req, we, addr, sel, wdata,
      input  rdata, ack
   );

   modport slave (
      input  req, we, addr, sel, wdata,
      output rdata, ack
   );
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: passes ALU results through, performs loads/stores over
// the req/ack data bus and registers the write-back triple.
// Optional build macro: MEM_ALIGN_CHECK_EN (misaligned half/word accesses
// complete immediately with misalign_o instead of issuing a bus cycle).
//
// state  | meaning
// S_IDLE | no access pending; accepts the next EX result
// S_BUS  | bus request outstanding, waiting for ack
module mem_access #(
   parameter int ADDR_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   input  logic                  flush_i,
   input  logic [3:0]            mem_op_i,
   input  logic [ADDR_W-1:0]     mem_addr_i,
   input  logic [31:0]           store_i,
   input  logic [REG_ADDR_W-1:0] wd_i,
   input  logic                  wreg_i,
   input  logic [31:0]           wdata_i,
   output logic                  stallreq_o,
   mem_access_if.master          bus,
   output logic                  valid_o,
   output logic [REG_ADDR_W-1:0] wd_o,
   output logic                  wreg_o,
   output logic [31:0]           wdata_o,
   output logic                  misalign_o
);

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd8;
   localparam logic [3:0] OP_SH  = 4'd9;
   localparam logic [3:0] OP_SW  = 4'd10;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic {S_IDLE, S_BUS} state_t;

   state_t                  state_q, state_d;
   logic                    is_load, is_store;
   logic [1:0]              size;
   logic [3:0]              sel_n;
   logic [31:0]             wdata_n;
   logic                    misalign;
   logic                    issue;
   logic [3:0]              op_q;
   logic [1:0]              off_q;
   logic [REG_ADDR_W-1:0]   wd_q;
   logic                    flush_q;
   logic [7:0]              lane_b;
   logic [15:0]             lane_h;
   logic [31:0]             ld_data;
   logic                    ld_wreg;

   // decode the incoming memory op into direction and access size
   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      size     = SZ_B;
      case (mem_op_i)
         OP_LB, OP_LBU: begin is_load  = 1'b1; size = SZ_B; end
         OP_LH, OP_LHU: begin is_load  = 1'b1; size = SZ_H; end
         OP_LW:         begin is_load  = 1'b1; size = SZ_W; end
         OP_SB:         begin is_store = 1'b1; size = SZ_B; end
         OP_SH:         begin is_store = 1'b1; size = SZ_H; end
         OP_SW:         begin is_store = 1'b1; size = SZ_W; end
         default:       ;
      endcase
   end

   // byte enables and lane-replicated store data; loads use the same enables
   always_comb begin
      sel_n   = 4'b1111;
      wdata_n = store_i;
      case (size)
         SZ_B: begin
            sel_n   = 4'b0001 << mem_addr_i[1:0];
            wdata_n = {4{store_i[7:0]}};
         end
         SZ_H: begin
            sel_n   = 4'b0011 << {mem_addr_i[1], 1'b0};
            wdata_n = {2{store_i[15:0]}};
         end
         default: ;
      endcase
   end

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign = ((size == SZ_H) && mem_addr_i[0]) ||
                     ((size == SZ_W) && (mem_addr_i[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign issue = (state_q == S_IDLE) && valid_i && !flush_i &&
                  (is_load || is_store) && !misalign;

   // pick the addressed lane out of the returned word and extend it
   always_comb begin
      lane_b  = bus.rdata[{off_q, 3'b000} +: 8];
      lane_h  = off_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];
      ld_data = 32'h0;
      ld_wreg = 1'b1;
      case (op_q)
         OP_LB:   ld_data = {{24{lane_b[7]}}, lane_b};
         OP_LBU:  ld_data = {24'h0, lane_b};
         OP_LH:   ld_data = {{16{lane_h[15]}}, lane_h};
         OP_LHU:  ld_data = {16'h0, lane_h};
         OP_LW:   ld_data = bus.rdata;
         default: ld_wreg = 1'b0;
      endcase
   end

   // next state and stall request; the ack cycle itself does not stall
   always_comb begin
      state_d    = state_q;
      stallreq_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (issue) begin
               state_d    = S_BUS;
               stallreq_o = 1'b1;
            end
         end
         S_BUS: begin
            if (bus.ack) state_d = S_IDLE;
            else         stallreq_o = 1'b1;
         end
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // bus drive, access context and write-back registers
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.req    <= 1'b0;
         bus.we     <= 1'b0;
         bus.addr   <= '0;
         bus.sel    <= 4'h0;
         bus.wdata  <= 32'h0;
         op_q       <= 4'h0;
         off_q      <= 2'b00;
         wd_q       <= '0;
         flush_q    <= 1'b0;
         valid_o    <= 1'b0;
         wd_o       <= '0;
         wreg_o     <= 1'b0;
         wdata_o    <= 32'h0;
         misalign_o <= 1'b0;
      end else begin
         valid_o    <= 1'b0;
         wreg_o     <= 1'b0;
         misalign_o <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (valid_i && !flush_i) begin
                  if (!(is_load || is_store)) begin
                     valid_o <= 1'b1;
                     wd_o    <= wd_i;
                     wreg_o  <= wreg_i;
                     wdata_o <= wdata_i;
                  end else if (misalign) begin
                     valid_o    <= 1'b1;
                     wd_o       <= wd_i;
                     wdata_o    <= 32'h0;
                     misalign_o <= 1'b1;
                  end else begin
                     bus.req   <= 1'b1;
                     bus.we    <= is_store;
                     bus.addr  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                     bus.sel   <= sel_n;
                     bus.wdata <= wdata_n;
                     op_q      <= mem_op_i;
                     off_q     <= mem_addr_i[1:0];
                     wd_q      <= wd_i;
                     flush_q   <= 1'b0;
                  end
               end
            end
            S_BUS: begin
               // a flush cannot abort the bus cycle; remember it and drop the result
               if (flush_i) flush_q <= 1'b1;
               if (bus.ack) begin
                  bus.req <= 1'b0;
                  bus.we  <= 1'b0;
                  if (!flush_i && !flush_q) begin
                     valid_o <= 1'b1;
                     wd_o    <= wd_q;
                     wreg_o  <= ld_wreg;
                     wdata_o <= ld_data;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, loads, stores, flush, reset
// during a bus cycle and misaligned accesses (MEM_ALIGN_CHECK_EN aware).
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic        flush_i;
   logic [3:0]  mem_op_i;
   logic [31:0] mem_addr_i;
   logic [31:0] store_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [31:0] wdata_i;
   logic        stallreq_o;
   logic        valid_o;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        misalign_o;

   int vectors = 0;
   int miscompares = 0;

   mem_access_if #(.ADDR_W(32)) bus_if ();

   mem_access #(.ADDR_W(32), .REG_ADDR_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (valid_i),
      .flush_i    (flush_i),
      .mem_op_i   (mem_op_i),
      .mem_addr_i (mem_addr_i),
      .store_i    (store_i),
      .wd_i       (wd_i),
      .wreg_i     (wreg_i),
      .wdata_i    (wdata_i),
      .stallreq_o (stallreq_o),
      .bus        (bus_if.master),
      .valid_o    (valid_o),
      .wd_o       (wd_o),
      .wreg_o     (wreg_o),
      .wdata_o    (wdata_o),
      .misalign_o (misalign_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      valid_i    = 1'b0;
      flush_i    = 1'b0;
      mem_op_i   = 4'd0;
      mem_addr_i = 32'h0;
      store_i    = 32'h0;
      wd_i       = 5'd0;
      wreg_i     = 1'b0;
      wdata_i    = 32'h0;
      bus_if.ack   = 1'b0;
      bus_if.rdata = 32'h0;
   endtask

   // flush_mode: 0 none, 1 flush on first wait cycle, 2 flush on ack cycle
   task automatic run_access(input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] store, input logic [31:0] rdata,
                             input int waits, input int flush_mode,
                             output int stalls, output logic [3:0] sel,
                             output logic [31:0] baddr, output logic [31:0] bwdata,
                             output logic we, output logic v, output logic wr,
                             output logic [31:0] wdo, output logic req_after);
      valid_i    = 1'b1;
      mem_op_i   = op;
      mem_addr_i = addr;
      store_i    = store;
      wd_i       = 5'd7;
      wreg_i     = 1'b1;
      wdata_i    = 32'hDEAD_0000;
      #1;
      stalls = 0;
      if (stallreq_o) stalls++;
      step();
      sel    = bus_if.sel;
      baddr  = bus_if.addr;
      bwdata = bus_if.wdata;
      we     = bus_if.we;
      for (int i = 0; i < waits; i++) begin
         flush_i = (flush_mode == 1 && i == 0);
         #1;
         if (stallreq_o) stalls++;
         step();
         flush_i = 1'b0;
      end
      bus_if.ack   = 1'b1;
      bus_if.rdata = rdata;
      flush_i      = (flush_mode == 2);
      #1;
      if (stallreq_o) stalls++;
      step();
      bus_if.ack = 1'b0;
      flush_i    = 1'b0;
      valid_i    = 1'b0;
      v         = valid_o;
      wr        = wreg_o;
      wdo       = wdata_o;
      req_after = bus_if.req;
      step();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      vectors++;
      if ({valid_o, wreg_o, bus_if.req, bus_if.we, misalign_o} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b want 00000", {valid_o, wreg_o, bus_if.req, bus_if.we, misalign_o});
      end
      vectors++;
      if ({wd_o, wdata_o} !== 37'h0) begin
         miscompares++;
         $display("FAIL reset_wb: got wd=%0d wdata=%h want 0", wd_o, wdata_o);
      end
      vectors++;
      if ({bus_if.addr, bus_if.sel, bus_if.wdata} !== 68'h0) begin
         miscompares++;
         $display("FAIL reset_bus: got addr=%h sel=%b wdata=%h want 0", bus_if.addr, bus_if.sel, bus_if.wdata);
      end
   endtask

   task automatic test_none();
      valid_i  = 1'b1;
      mem_op_i = 4'd0;
      wd_i     = 5'd3;
      wreg_i   = 1'b1;
      wdata_i  = 32'h1234;
      #1;
      vectors++;
      if (stallreq_o !== 1'b0) begin
         miscompares++;
         $display("FAIL none_stall: got %b want 0", stallreq_o);
      end
      step();
      valid_i = 1'b0;
      vectors++;
      if ({valid_o, wd_o, wreg_o, wdata_o, bus_if.req} !== {1'b1, 5'd3, 1'b1, 32'h1234, 1'b0}) begin
         miscompares++;
         $display("FAIL none_wb: got v=%b wd=%0d wr=%b data=%h req=%b want 1 3 1 00001234 0",
                  valid_o, wd_o, wreg_o, wdata_o, bus_if.req);
      end
      step();
      vectors++;
      if ({valid_o, wreg_o} !== 2'b00) begin
         miscompares++;
         $display("FAIL none_drop: got v=%b wr=%b want 0 0", valid_o, wreg_o);
      end
   endtask

   task automatic test_loads();
      int s; logic [3:0] sel; logic [31:0] a, bw, d; logic we, v, wr, rq;
      run_access(4'd1, 32'h1003, 32'h0, 32'h8012_3456, 3, 0, s, sel, a, bw, we, v, wr, d, rq);
      vectors++;
      if ({sel, a, we} !== {4'b1000, 32'h1000, 1'b0}) begin
         miscompares++;
         $display("FAIL lb_bus: got sel=%b addr=%h we=%b want 1000 00001000 0", sel, a, we);
      end
      vectors++;
      if (s !== 4) begin
         miscompares++;
         $display("FAIL lb_stall: got %0d cycles want 4", s);
      end
      vectors++;
      if ({v, wr, d, rq} !== {1'b1, 1'b1, 32'hFFFF_FF80, 1'b0}) begin
         miscompares++;
         $display("FAIL lb_wb: got v=%b wr=%b data=%h req=%b want 1 1 ffffff80 0", v, wr, d, rq);
      end
      run_access(4'd2, 32'h1003, 32'h0, 32'h8012_3456, 3, 0, s, sel, a, bw, we, v, wr, d, rq);
      vectors++;
      if ({v, wr, d} !== {1'b1, 1'b1, 32'h0000_0080}) begin
         miscompares++;
         $display("FAIL lbu_wb: got v=%b wr=%b data=%h want 1 1 00000080", v, wr, d);
      end
      run_access(4'd3, 32'h1002, 32'h0, 32'hBEEF_0000, 1, 0, s, sel, a, bw, we, v, wr, d, rq);
      vectors++;
      if ({sel, d} !== {4'b1100, 32'hFFFF_BEEF}) begin
         miscompares++;
         $display("FAIL lh_hi: got sel=%b data=%h want 1100 ffffbeef", sel, d);
      end
      run_access(4'd4, 32'h1000, 32'h0, 32'h1234_F00D, 1, 0, s, sel, a, bw, we, v, wr, d, rq);
      vectors++;
      if ({sel, d} !== {4'b0011, 32'h0000_F00D}) begin
         miscompares++;
         $display("FAIL lhu_lo: got sel=%b data=%h want 0011 0000f00d", sel, d);
      end
      run_access(4'd5, 32'h1004, 32'h0, 32'hCAFE_F00D, 0, 0, s, sel, a, bw, we, v, wr, d, rq);
      vectors++;
      if ({sel, a, d, s} !== {4'b1111, 32'h1004, 32'hCAFE_F00D, 32'd1}) begin
         miscompares++;
         $display("FAIL lw_fast: got sel=%b addr=%h data=%h stalls=%0d want 1111 00001004 cafef00d 1", sel, a, d, s);
      end
   endtask

   task automatic test_stores();
      int s; logic [3:0] sel; logic [31:0] a, bw, d; logic we, v, wr, rq;
      run_access(4'd9, 32'h2002, 32'h0000_BEEF, 32'hFFFF_FFFF, 2, 0, s, sel, a, bw, we, v, wr, d, rq);
      vectors++;
      if ({we, sel, a, bw} !== {1'b1, 4'b1100, 32'h2000, 32'hBEEF_BEEF}) begin
         miscompares++;
         $display("FAIL sh_bus: got we=%b sel=%b addr=%h wdata=%h want 1 1100 00002000 beefbeef", we, sel, a, bw);
      end
      vectors++;
      if ({v, wr, d} !== {1'b1, 1'b0, 32'h0}) begin
         miscompares++;
         $display("FAIL sh_wb: got v=%b wr=%b data=%h want 1 0 0", v, wr, d);
      end
      run_access(4'd8, 32'h2001, 32'h1234_5678, 32'h0, 0, 0, s, sel, a, bw, we, v, wr, d, rq);
      vectors++;
      if ({we, sel, bw} !== {1'b1, 4'b0010, 32'h7878_7878}) begin
         miscompares++;
         $display("FAIL sb_bus: got we=%b sel=%b wdata=%h want 1 0010 78787878", we, sel, bw);
      end
   endtask

   task automatic test_flush();
      int s; logic [3:0] sel; logic [31:0] a, bw, d; logic we, v, wr, rq;
      run_access(4'd5, 32'h1000, 32'h0, 32'h1111_2222, 2, 1, s, sel, a, bw, we, v, wr, d, rq);
      vectors++;
      if ({v, wr, rq, s} !== {1'b0, 1'b0, 1'b0, 32'd3}) begin
         miscompares++;
         $display("FAIL flush_bus: got v=%b wr=%b req=%b stalls=%0d want 0 0 0 3", v, wr, rq, s);
      end
      run_access(4'd5, 32'h1000, 32'h0, 32'h1111_2222, 1, 2, s, sel, a, bw, we, v, wr, d, rq);
      vectors++;
      if ({v, rq} !== 2'b00) begin
         miscompares++;
         $display("FAIL flush_ack: got v=%b req=%b want 0 0", v, rq);
      end
      valid_i    = 1'b1;
      flush_i    = 1'b1;
      mem_op_i   = 4'd5;
      mem_addr_i = 32'h1000;
      #1;
      vectors++;
      if (stallreq_o !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_idle_stall: got %b want 0", stallreq_o);
      end
      step();
      valid_i = 1'b0;
      flush_i = 1'b0;
      vectors++;
      if ({bus_if.req, valid_o} !== 2'b00) begin
         miscompares++;
         $display("FAIL flush_idle: got req=%b v=%b want 0 0", bus_if.req, valid_o);
      end
      step();
   endtask

   task automatic test_reset_in_bus();
      valid_i    = 1'b1;
      mem_op_i   = 4'd5;
      mem_addr_i = 32'h4000;
      wd_i       = 5'd9;
      step();
      vectors++;
      if (bus_if.req !== 1'b1) begin
         miscompares++;
         $display("FAIL rstbus_issue: got req=%b want 1", bus_if.req);
      end
      rst     = 1'b1;
      valid_i = 1'b0;
      step();
      rst = 1'b0;
      vectors++;
      if ({bus_if.req, bus_if.sel, bus_if.addr, valid_o, wreg_o} !== 39'h0) begin
         miscompares++;
         $display("FAIL rstbus_clear: got req=%b sel=%b addr=%h v=%b wr=%b want all 0",
                  bus_if.req, bus_if.sel, bus_if.addr, valid_o, wreg_o);
      end
      bus_if.ack   = 1'b1;
      bus_if.rdata = 32'h5555_5555;
      step();
      bus_if.ack = 1'b0;
      vectors++;
      if ({valid_o, wreg_o, bus_if.req, wdata_o} !== 35'h0) begin
         miscompares++;
         $display("FAIL rstbus_lateack: got v=%b wr=%b req=%b data=%h want 0", valid_o, wreg_o, bus_if.req, wdata_o);
      end
   endtask

   task automatic test_back_to_back();
      valid_i  = 1'b1;
      mem_op_i = 4'd0;
      wd_i     = 5'd4;
      wreg_i   = 1'b1;
      wdata_i  = 32'hA;
      step();
      wd_i    = 5'd5;
      wdata_i = 32'hB;
      vectors++;
      if ({valid_o, wd_o, wdata_o} !== {1'b1, 5'd4, 32'hA}) begin
         miscompares++;
         $display("FAIL b2b_first: got v=%b wd=%0d data=%h want 1 4 a", valid_o, wd_o, wdata_o);
      end
      step();
      valid_i = 1'b0;
      vectors++;
      if ({valid_o, wd_o, wdata_o} !== {1'b1, 5'd5, 32'hB}) begin
         miscompares++;
         $display("FAIL b2b_second: got v=%b wd=%0d data=%h want 1 5 b", valid_o, wd_o, wdata_o);
      end
      step();
   endtask

   task automatic test_misalign();
`ifdef MEM_ALIGN_CHECK_EN
      valid_i    = 1'b1;
      mem_op_i   = 4'd5;
      mem_addr_i = 32'h3001;
      wd_i       = 5'd12;
      wreg_i     = 1'b1;
      #1;
      vectors++;
      if (stallreq_o !== 1'b0) begin
         miscompares++;
         $display("FAIL misalign_stall: got %b want 0", stallreq_o);
      end
      step();
      valid_i = 1'b0;
      vectors++;
      if ({bus_if.req, misalign_o, valid_o, wreg_o, wd_o} !== {1'b0, 1'b1, 1'b1, 1'b0, 5'd12}) begin
         miscompares++;
         $display("FAIL misalign_wb: got req=%b mis=%b v=%b wr=%b wd=%0d want 0 1 1 0 12",
                  bus_if.req, misalign_o, valid_o, wreg_o, wd_o);
      end
      step();
      vectors++;
      if (misalign_o !== 1'b0) begin
         miscompares++;
         $display("FAIL misalign_pulse: got %b want 0", misalign_o);
      end
`else
      int s; logic [3:0] sel; logic [31:0] a, bw, d; logic we, v, wr, rq;
      run_access(4'd5, 32'h3001, 32'h0, 32'h7777_0000, 0, 0, s, sel, a, bw, we, v, wr, d, rq);
      vectors++;
      if ({a, sel, misalign_o, d} !== {32'h3000, 4'b1111, 1'b0, 32'h7777_0000}) begin
         miscompares++;
         $display("FAIL unaligned_lw: got addr=%h sel=%b mis=%b data=%h want 00003000 1111 0 77770000",
                  a, sel, misalign_o, d);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_none();
      test_loads();
      test_stores();
      test_flush();
      test_reset_in_bus();
      test_back_to_back();
      test_misalign();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
